pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: fetch, jump and save operations on a
// 16-bit PC split into two DATA_WIDTH halves sharing one data bus.
module pc_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic jump_req,
    input  logic save_req,
    input  logic mem_ready,
    input  logic pc_carry,
    input  logic wrap_clr,
    output logic pc_cs,
    output logic pc_oe_a,
    output logic pc_cnt_en,
    output logic pc_we_l,
    output logic pc_we_h,
    output logic pc_oe_l,
    output logic pc_oe_h,
    output logic mem_rd,
    output logic ir_we,
    output logic busy,
    output logic ack,
    output logic err,
    output logic wrap
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] W_LAST = CW'(TIMEOUT - 1);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("pc_sequencer: DATA_WIDTH must be at least 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("pc_sequencer: TIMEOUT must be in 1..255");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_INC, S_JMP_L,
        S_JMP_H, S_SAVE_L, S_SAVE_H, S_DONE, S_ERR
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait;
    logic            r_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            // Setting on a carry out of INC takes precedence over a clear.
            if (r_state == S_INC && pc_carry)
                r_wrap <= 1'b1;
            else if (wrap_clr)
                r_wrap <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (jump_req)
                        r_state <= S_JMP_L;
                    else if (save_req)
                        r_state <= S_SAVE_L;
                    else if (fetch_req)
                        r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // Read data arriving on the last allowed cycle still wins.
                    if (mem_ready)
                        r_state <= S_LATCH;
                    else if (r_wait == W_LAST)
                        r_state <= S_ERR;
                    else
                        r_wait <= r_wait + 1'b1;
                end
                S_LATCH:  r_state <= S_INC;
                S_INC:    r_state <= S_DONE;
                S_JMP_L:  r_state <= S_JMP_H;
                S_JMP_H:  r_state <= S_DONE;
                S_SAVE_L: r_state <= S_SAVE_H;
                S_SAVE_H: r_state <= S_DONE;
                S_DONE:   r_state <= S_IDLE;
                S_ERR:    r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_cs     = 1'b0;
        pc_oe_a   = 1'b0;
        pc_cnt_en = 1'b0;
        pc_we_l   = 1'b0;
        pc_we_h   = 1'b0;
        pc_oe_l   = 1'b0;
        pc_oe_h   = 1'b0;
        mem_rd    = 1'b0;
        ir_we     = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_FETCH:  begin pc_cs = 1'b1; pc_oe_a = 1'b1; mem_rd = 1'b1; end
            S_LATCH:  begin pc_cs = 1'b1; pc_oe_a = 1'b1; ir_we  = 1'b1; end
            S_INC:    begin pc_cs = 1'b1; pc_cnt_en = 1'b1; end
            S_JMP_L:  begin pc_cs = 1'b1; pc_we_l = 1'b1; end
            S_JMP_H:  begin pc_cs = 1'b1; pc_we_h = 1'b1; end
            S_SAVE_L: begin pc_cs = 1'b1; pc_oe_l = 1'b1; end
            S_SAVE_H: begin pc_cs = 1'b1; pc_oe_h = 1'b1; end
            S_DONE:   ack = 1'b1;
            S_ERR:    err = 1'b1;
            default:  ;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign wrap = r_wrap;

endmodule
